mem_stage_lsu: RTL

- Parametrised memory-access pipeline stage, successor to the fixed 32-bit memory stage.
- Owns its own load/store request handshake, byte-lane alignment, sign/zero extension and misalignment detection.
- Configurable DATA_W (32 or 64), with valid/ready flow control replacing the global stall vector.
- Sits between the execute stage and the writeback stage. Survives flushes while a load is outstanding by draining the orphaned response.

---
 rtl/mem_stage_lsu.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: load/store request handshake, byte-lane alignment,
// load extension and misalignment detection, with flush-safe draining of orphaned loads.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              es_valid,
  output logic              es_ready,
  input  logic              es_mem_en,
  input  logic              es_mem_we,
  input  logic [1:0]        es_size,
  input  logic              es_unsigned,
  input  logic [ADDR_W-1:0] es_addr,
  input  logic [DATA_W-1:0] es_wdata,
  input  logic [DATA_W-1:0] es_result,
  input  logic              es_reg_we,
  input  logic [4:0]        es_dest,
  input  logic [PC_W-1:0]   es_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ms_valid,
  input  logic              ws_ready,
  output logic              ms_reg_we,
  output logic [4:0]        ms_dest,
  output logic [DATA_W-1:0] ms_result,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_ale,
  output logic              ms_load_pending
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state;

  logic                     req_we_p0;
  logic [ADDR_W-1:0]        req_addr_p0;
  logic [STRB_W-1:0]        req_wstrb_p0;
  logic [DATA_W-1:0]        req_wdata_p0;
  logic [1:0]               req_size_p0;
  logic                     req_uns_p0;
  logic [OFF_W-1:0]         req_off_p0;

  logic signed [DATA_W-1:0] res_p1;
  logic                     reg_we_p1;
  logic [4:0]               dest_p1;
  logic [PC_W-1:0]          pc_p1;
  logic                     ale_p1;
  logic                     vld_p1;

  logic accept;

  // A dword access can never be aligned on a 32-bit datapath.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic [2:0] low_mask;
    low_mask = 3'((4'd1 << size) - 4'd1);
    is_misaligned = ((addr[2:0] & low_mask) != 3'd0) || (size == 2'd3 && DATA_W == 32);
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off, input logic [1:0] size);
    logic [STRB_W-1:0] base;
    case (size)
      2'd0:    base = STRB_W'(1);
      2'd1:    base = STRB_W'(3);
      2'd2:    base = STRB_W'(15);
      default: base = '1;
    endcase
    lane_strb = base << off;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [DATA_W-1:0] wd, input logic [1:0] size);
    logic [DATA_W-1:0] r;
    int nbytes;
    nbytes = 1 << size;
    if (nbytes > STRB_W) nbytes = STRB_W;
    for (int i = 0; i < STRB_W; i++) r[i*8 +: 8] = wd[(i % nbytes)*8 +: 8];
    lane_wdata = r;
  endfunction

  function automatic logic signed [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rd,
                                                        input logic [OFF_W-1:0]  off,
                                                        input logic [1:0]        size,
                                                        input logic              uns);
    logic [DATA_W-1:0]        sh;
    logic signed [DATA_W-1:0] r;
    int nbits;
    sh = rd >> {off, 3'b000};
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? sh[i] : (!uns & sh[nbits-1]);
    load_ext = r;
  endfunction

  assign es_ready = !reset && (state == S_IDLE || (state == S_DONE && ws_ready));
  assign accept   = es_valid && es_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_we_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_wstrb_p0 <= '0;
      req_wdata_p0 <= '0;
      req_size_p0  <= '0;
      req_uns_p0   <= 1'b0;
      req_off_p0   <= '0;
      res_p1       <= '0;
      reg_we_p1    <= 1'b0;
      dest_p1      <= '0;
      pc_p1        <= '0;
      ale_p1       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (accept) begin
            dest_p1   <= es_dest;
            pc_p1     <= es_pc;
            ale_p1    <= 1'b0;
            reg_we_p1 <= es_reg_we;
            if (!es_mem_en) begin
              res_p1 <= $signed(es_result);
              state  <= S_DONE;
            end else if (is_misaligned(es_addr, es_size)) begin
              res_p1    <= $signed(DATA_W'(es_addr));
              ale_p1    <= 1'b1;
              reg_we_p1 <= 1'b0;
              state     <= S_DONE;
            end else begin
              // Request stage (p0)
              req_we_p0    <= es_mem_we;
              req_addr_p0  <= {es_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              req_wstrb_p0 <= es_mem_we ? lane_strb(es_addr[OFF_W-1:0], es_size) : '0;
              req_wdata_p0 <= es_mem_we ? lane_wdata(es_wdata, es_size) : '0;
              req_size_p0  <= es_size;
              req_uns_p0   <= es_unsigned;
              req_off_p0   <= es_addr[OFF_W-1:0];
              state        <= S_REQ;
            end
          end else if (state == S_DONE && ws_ready) begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            if (flush)          state <= req_we_p0 ? S_IDLE : S_DRAIN;
            else if (req_we_p0) state <= S_DONE;
            else                state <= S_WAIT;
            if (!flush && req_we_p0) begin
              reg_we_p1 <= 1'b0;
              res_p1    <= '0;
            end
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        // Result stage (p1)
        S_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              res_p1 <= load_ext(mem_rdata, req_off_p0, req_size_p0, req_uns_p0);
              state  <= S_DONE;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign vld_p1          = (state == S_DONE);
  assign mem_req         = (state == S_REQ);
  assign mem_we          = req_we_p0;
  assign mem_addr        = req_addr_p0;
  assign mem_wstrb       = req_wstrb_p0;
  assign mem_wdata       = req_wdata_p0;
  assign ms_valid        = vld_p1;
  assign ms_reg_we       = reg_we_p1;
  assign ms_dest         = dest_p1;
  assign ms_result       = res_p1;
  assign ms_pc           = pc_p1;
  assign ms_ale          = ale_p1;
  assign ms_load_pending = (state == S_REQ) || (state == S_WAIT);

endmodule
